instr_fetch: RTL and testbench

- Fetch-side datapath block that sits between the 8-bit memory data bus and the CPU control FSM.
- Holds the program counter and assembles a 16-bit instruction from two consecutive byte reads.
- Drives the memory address mux and supplies the opcode back to the control FSM.
- Consumes the control FSM's ld_ir, ld_pc, inc_pc, sel and halt strobes.

---
 rtl/instr_fetch.sv | 52 +++++
 tb/tb_instr_fetch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, two-byte instruction assembly and memory address mux for the CPU fetch path
module instr_fetch #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int PC_W   = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data,
    input  logic                       ld_ir,
    input  logic                       ld_pc,
    input  logic                       inc_pc,
    input  logic                       sel,
    input  logic                       halt,
    output logic [2*DATA_W-ADDR_W-1:0] opcode,
    output logic [ADDR_W-1:0]          ir_addr,
    output logic [PC_W-1:0]            pc,
    output logic [ADDR_W-1:0]          addr,
    output logic                       ir_valid,
    output logic                       halted
);
    typedef enum logic {HI = 1'b0, LO = 1'b1} ptr_t;
    ptr_t state, state_nx;
    logic [2*DATA_W-1:0] ir;
    logic run;
    assign run     = !halted;
    assign opcode  = ir[2*DATA_W-1:ADDR_W];
    assign ir_addr = ir[ADDR_W-1:0];
    assign addr    = sel ? {pc, state == LO} : ir_addr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= HI;
        else state <= state_nx;
    // a gap in ld_ir resynchronises to the high byte; halt freezes the pointer
    always_comb begin
        state_nx = HI;
        state_nx = !run ? state : (ld_ir && state == HI) ? LO : HI;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            ir       <= '0;
            pc       <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            halted   <= halted | halt;
            ir_valid <= run && ld_ir && state == LO;
            if (run && ld_ir && state == HI) ir[2*DATA_W-1:DATA_W] <= data;
            if (run && ld_ir && state == LO) ir[DATA_W-1:0] <= data;
            if (run && ld_pc) pc <= ir[ADDR_W-1:1];
            else if (run && inc_pc) pc <= pc + 1'b1;
        end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch/jump/halt/reset vectors checked every cycle against a word-level model
module tb_instr_fetch;
    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic ld_ir = 0, ld_pc = 0, inc_pc = 0, sel = 1, halt = 0;
    logic [2:0] opcode;
    logic [12:0] ir_addr, addr;
    logic [11:0] pc;
    logic ir_valid, halted;
    int errors = 0, checks = 0;
    int m_ir = 0, m_pc = 0, m_ptr = 0, m_valid = 0, m_halt = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .data(data), .ld_ir(ld_ir), .ld_pc(ld_pc),
        .inc_pc(inc_pc), .sel(sel), .halt(halt), .opcode(opcode),
        .ir_addr(ir_addr), .pc(pc), .addr(addr), .ir_valid(ir_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // word-level model: ir is a 16-bit number, pc a 12-bit counter, ptr counts bytes of the current fetch
    always @(negedge rst) begin
        m_ir = 0; m_pc = 0; m_ptr = 0; m_valid = 0; m_halt = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_ir = 0; m_pc = 0; m_ptr = 0; m_valid = 0; m_halt = 0;
        end else if (m_halt != 0) begin
            m_valid = 0;
        end else begin
            int nir, npc, nptr, nv;
            nir = m_ir; nptr = 0; nv = 0;
            if (ld_ir && m_ptr == 0) begin
                nir = int'(data) * 256 + m_ir % 256;
                nptr = 1;
            end else if (ld_ir) begin
                nir = (m_ir / 256) * 256 + int'(data);
                nv = 1;
            end
            npc = ld_pc ? (m_ir % 8192) / 2 : inc_pc ? (m_pc + 1) % 4096 : m_pc;
            m_ir = nir; m_pc = npc; m_ptr = nptr; m_valid = nv;
            if (halt) m_halt = 1;
        end
    end

    always @(negedge clk) begin
        chk("opcode", int'(opcode), m_ir / 8192);
        chk("ir_addr", int'(ir_addr), m_ir % 8192);
        chk("pc", int'(pc), m_pc);
        chk("addr", int'(addr), sel ? m_pc * 2 + m_ptr : m_ir % 8192);
        chk("ir_valid", int'(ir_valid), m_valid);
        chk("halted", int'(halted), m_halt);
    end

    // apply strobes at negedge+1, let one rising edge pass, return at the next negedge+1
    task automatic cyc(input logic li, input logic lp, input logic ip, input logic h, input logic [7:0] d);
        ld_ir = li; ld_pc = lp; inc_pc = ip; halt = h; data = d;
        @(posedge clk);
        @(negedge clk);
        #1;
        ld_ir = 0; ld_pc = 0; inc_pc = 0; halt = 0;
    endtask

    task automatic fetch(input logic [7:0] hi, input logic [7:0] lo);
        ld_ir = 1; data = hi;
        @(posedge clk); @(negedge clk); #1;
        data = lo;
        @(posedge clk); @(negedge clk); #1;
        ld_ir = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1;
        chk("lit_reset_addr", int'(addr), 0);
        chk("lit_reset_pc", int'(pc), 0);
        // first fetch: addr 0 then 1
        ld_ir = 1; data = 8'hA1;
        chk("lit_addr_byte0", int'(addr), 0);
        @(posedge clk); @(negedge clk); #1;
        chk("lit_opcode_early", int'(opcode), 3'b101);
        data = 8'h23;
        chk("lit_addr_byte1", int'(addr), 1);
        @(posedge clk); @(negedge clk); #1;
        ld_ir = 0;
        chk("lit_ir_addr", int'(ir_addr), 13'h0123);
        chk("lit_opcode", int'(opcode), 3'b101);
        chk("lit_valid_hi", int'(ir_valid), 1);
        cyc(0, 0, 0, 0, 8'h00);
        chk("lit_valid_lo", int'(ir_valid), 0);
        // increment
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        chk("lit_pc3", int'(pc), 12'h003);
        chk("lit_addr6", int'(addr), 13'h0006);
        // wrap via load of 0xFFF
        fetch(8'h1F, 8'hFE);
        cyc(0, 1, 0, 0, 8'h00);
        chk("lit_pc_fff", int'(pc), 12'hFFF);
        cyc(0, 0, 1, 0, 8'h00);
        chk("lit_pc_wrap", int'(pc), 0);
        // jump: load wins over increment
        fetch(8'hE0, 8'hA4);
        cyc(0, 1, 1, 0, 8'h00);
        chk("lit_jump_pc", int'(pc), 12'h052);
        sel = 0;
        #1 chk("lit_sel0_addr", int'(addr), 13'h00A4);
        sel = 1;
        // lone strobe, then resync
        fetch(8'h12, 8'h34);
        cyc(1, 0, 0, 0, 8'h5A);
        chk("lit_lone_ir", {29'd0, opcode, ir_addr}, 16'h5A34);
        chk("lit_lone_valid", int'(ir_valid), 0);
        cyc(0, 0, 0, 0, 8'h00);
        fetch(8'h77, 8'h88);
        chk("lit_resync_ir", {29'd0, opcode, ir_addr}, 16'h7788);
        // fetch/jump overlap: increment during capture
        ld_ir = 1; inc_pc = 1; data = 8'h3C;
        @(posedge clk); @(negedge clk); #1;
        ld_ir = 0; inc_pc = 0;
        cyc(0, 0, 0, 0, 8'h00);
        // halt at pc 0x010 together with inc_pc
        fetch(8'h00, 8'h20);
        cyc(0, 1, 0, 0, 8'h00);
        chk("lit_pc10", int'(pc), 12'h010);
        cyc(0, 0, 1, 1, 8'h00);
        chk("lit_halt_pc", int'(pc), 12'h011);
        chk("lit_halted", int'(halted), 1);
        cyc(1, 1, 1, 0, 8'hFF);
        cyc(1, 1, 1, 0, 8'hFF);
        chk("lit_frozen_pc", int'(pc), 12'h011);
        chk("lit_frozen_ir", {29'd0, opcode, ir_addr}, 16'h0020);
        chk("lit_frozen_valid", int'(ir_valid), 0);
        chk("lit_still_halted", int'(halted), 1);
        rst = 0;
        #1;
        chk("lit_rst_pc", int'(pc), 0);
        chk("lit_rst_ir", {29'd0, opcode, ir_addr}, 0);
        chk("lit_rst_halted", int'(halted), 0);
        chk("lit_rst_addr", int'(addr), 0);
        @(negedge clk); #1 rst = 1;
        // async reset between the two captures
        cyc(1, 0, 0, 0, 8'h99);
        #2 rst = 0;
        #2 rst = 1;
        @(negedge clk); #1;
        chk("lit_midrst_addr", int'(addr), 0);
        fetch(8'h40, 8'h01);
        chk("lit_midrst_ir", {29'd0, opcode, ir_addr}, 16'h4001);
        chk("lit_midrst_valid", int'(ir_valid), 1);
        repeat (2) cyc(0, 0, 0, 0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
